reg_dump_unit: RTL



---
 rtl/reg_dump_unit_pkg.sv | 33 +++
 rtl/reg_dump_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/reg_dump_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_unit_pkg
// Purpose  : Shared debug-path definitions for the register dump serializer.
// Revision : 1.0 - initial release
// ============================================================================
package reg_dump_unit_pkg;

    localparam int BYTE_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_LATCH = ST_LATCH,
        S_SEND  = ST_SEND,
        S_WAIT  = ST_WAIT
    } state_t;

    // Byte counter width for a register of reg_width bits; never narrower than 1.
    function automatic int byte_cnt_width(input int reg_width);
        int n;
        n = reg_width / BYTE_W;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_unit
// Purpose  : Reads every register through the debug port and streams it,
//            MSB byte first, over a start/done byte handshake.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    output logic [W-1:0]   o_dbg_addr,
    input  logic [B-1:0]   i_dbg_data,
    output logic [7:0]     o_tx_data,
    output logic           o_tx_start,
    input  logic           i_tx_done,
    output logic           o_busy,
    output logic           o_done
);

    localparam int                 c_num_bytes = B / BYTE_W;
    localparam int                 c_cnt_w     = byte_cnt_width(B);
    localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(c_num_bytes - 1);
    localparam logic [W-1:0]       c_last_addr = {W{1'b1}};

    state_t               r_state;
    logic [W-1:0]         r_addr;
    logic [B-1:0]         r_shift;
    logic [c_cnt_w-1:0]   r_byte_cnt;
    logic [BYTE_W-1:0]    r_tx_data;
    logic                 r_tx_start;
    logic                 r_busy;
    logic                 r_done;
    logic [B-1:0]         w_shift_next;

    assign w_shift_next = r_shift << BYTE_W;

    // Outputs are loaded on entry to the target state so every port is a flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_ADDR;
                        r_busy  <= 1'b1;
                    end
                end
                S_ADDR: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_shift    <= i_dbg_data;
                    r_byte_cnt <= '0;
                    r_tx_data  <= i_dbg_data[B-1 -: BYTE_W];
                    r_tx_start <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (r_byte_cnt != c_last_byte) begin
                            r_shift    <= w_shift_next;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_tx_data  <= w_shift_next[B-1 -: BYTE_W];
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEND;
                        end else if (r_addr != c_last_addr) begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_ADDR;
                        end else begin
                            r_addr  <= '0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dbg_addr = r_addr;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule
`default_nettype wire
